// File: rtl/vram_slot_arbiter.sv
// Shares one 64 KB RAM between CRTC video fetch and Z80 accesses on a fixed 16-cycle slot.
// Phases 0..8 always belong to video; phases 8..12 carry at most one CPU access.
module vram_slot_arbiter #(
  parameter int RAM_LAT = 1
) (
  input  logic        CLOCK,
  input  logic        nRESET,
  output logic        CRTC_CLKEN,
  input  logic [13:0] MA,
  input  logic [4:0]  RA,
  input  logic        CPU_REQ,
  input  logic        CPU_WE,
  input  logic [15:0] CPU_ADDR,
  input  logic [7:0]  CPU_DO,
  output logic [7:0]  CPU_DI,
  output logic        CPU_ACK,
  output logic        CPU_WAIT_n,
  output logic [15:0] RAM_ADDR,
  output logic        RAM_WE,
  output logic [7:0]  RAM_DO,
  input  logic [7:0]  RAM_DI,
  output logic [15:0] VID_DATA,
  output logic        VID_STB
);

  localparam logic [3:0] PH_VA0   = 4'd0;
  localparam logic [3:0] PH_VA1   = 4'd4;
  localparam logic [3:0] PH_VID   = 4'd7;
  localparam logic [3:0] PH_CPU   = 4'd8;
  localparam logic [3:0] PH_WE    = 4'd9;
  localparam logic [3:0] PH_ACK   = 4'd11;
  localparam logic [3:0] PH_DONE  = 4'd12;
  localparam logic [3:0] PH_CLKEN = 4'd14;
  localparam logic [3:0] PH_B0    = 4'(1 + RAM_LAT);
  localparam logic [3:0] PH_B1    = 4'(5 + RAM_LAT);
  localparam logic [3:0] PH_RD    = 4'(9 + RAM_LAT);

  typedef enum logic [1:0] {
    CPU_IDLE,
    CPU_GRANTED
  } cpu_state_t;

  cpu_state_t  cpu_state;
  cpu_state_t  cpu_state_next;
  logic [3:0]  ph;
  logic        cpu_we_l;
  logic [7:0]  byte0;
  logic [7:0]  byte1;
  logic        grant_take;
  logic        we_set;
  logic        ack_set;
  logic        di_take;
  logic [15:0] va0;
  logic [15:0] va1;
  logic        unused_bits;

  // MA[11:10] and RA[4:3] do not take part in the video address.
  assign va0         = {MA[13:12], RA[2:0], MA[9:0], 1'b0};
  assign va1         = {MA[13:12], RA[2:0], MA[9:0], 1'b1};
  assign unused_bits = ^{MA[11:10], RA[4:3]};

  // WAIT is released combinationally in the ACK cycle.
  assign CPU_WAIT_n = ~(CPU_REQ & ~CPU_ACK);

  always_ff @(posedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      ph         <= 4'd0;
      CRTC_CLKEN <= 1'b0;
      VID_STB    <= 1'b0;
    end else begin
      ph         <= ph + 4'd1;
      CRTC_CLKEN <= (ph == PH_CLKEN);
      VID_STB    <= (ph == PH_VID);
    end
  end

  always_ff @(posedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      cpu_state <= CPU_IDLE;
    end else begin
      cpu_state <= cpu_state_next;
    end
  end

  always_comb begin
    cpu_state_next = cpu_state;
    grant_take     = 1'b0;
    we_set         = 1'b0;
    ack_set        = 1'b0;
    di_take        = 1'b0;
    case (cpu_state)
      CPU_IDLE: begin
        if ((ph == PH_CPU) && CPU_REQ) begin
          grant_take     = 1'b1;
          cpu_state_next = CPU_GRANTED;
        end
      end
      CPU_GRANTED: begin
        we_set  = cpu_we_l && (ph == PH_WE);
        ack_set = (ph == PH_ACK);
        di_take = !cpu_we_l && (ph == PH_RD);
        if (ph == PH_DONE) begin
          cpu_state_next = CPU_IDLE;
        end
      end
      default: cpu_state_next = CPU_IDLE;
    endcase
  end

  // Without a grant the address simply holds VA(1) until the next slot.
  always_ff @(posedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      RAM_ADDR <= 16'd0;
      RAM_DO   <= 8'd0;
      RAM_WE   <= 1'b0;
      cpu_we_l <= 1'b0;
    end else begin
      RAM_WE <= we_set;
      if (ph == PH_VA0) begin
        RAM_ADDR <= va0;
      end else if (ph == PH_VA1) begin
        RAM_ADDR <= va1;
      end else if (grant_take) begin
        RAM_ADDR <= CPU_ADDR;
        RAM_DO   <= CPU_DO;
        cpu_we_l <= CPU_WE;
      end
    end
  end

  // With RAM_LAT=2 byte1 arrives on the same edge that publishes VID_DATA.
  always_ff @(posedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      byte0    <= 8'd0;
      byte1    <= 8'd0;
      VID_DATA <= 16'd0;
    end else begin
      if (ph == PH_B0) begin
        byte0 <= RAM_DI;
      end
      if (ph == PH_B1) begin
        byte1 <= RAM_DI;
      end
      if (ph == PH_VID) begin
        VID_DATA <= {((PH_B1 == PH_VID) ? RAM_DI : byte1), byte0};
      end
    end
  end

  always_ff @(posedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      CPU_ACK <= 1'b0;
      CPU_DI  <= 8'd0;
    end else begin
      CPU_ACK <= ack_set;
      if (di_take) begin
        CPU_DI <= RAM_DI;
      end
    end
  end

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Bench for vram_slot_arbiter: two instances (RAM_LAT 1 and 2) share stimulus and a slot-level model.
`timescale 1ns/1ps
module tb_vram_slot_arbiter;

  logic        clock;
  logic        rst_n;
  logic [13:0] ma;
  logic [4:0]  ra;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_do;

  logic        clken_1, ack_1, wait_n_1, ram_we_1, vid_stb_1;
  logic [7:0]  cpu_di_1, ram_do_1, ram_di_1, rd_stage_1;
  logic [15:0] ram_addr_1, vid_data_1;
  logic        clken_2, ack_2, wait_n_2, ram_we_2, vid_stb_2;
  logic [7:0]  cpu_di_2, ram_do_2, ram_di_2, rd_stage_2;
  logic [15:0] ram_addr_2, vid_data_2;

  logic [7:0]  mem_1  [0:65535];
  logic [7:0]  mem_2  [0:65535];
  logic [7:0]  shadow [0:65535];

  int checks   = 0;
  int failures = 0;

  int          m_ph      = 0;
  logic        t_valid   = 1'b0;
  logic        t_we      = 1'b0;
  logic [15:0] t_addr    = 16'd0;
  logic [7:0]  t_data    = 8'd0;
  logic [15:0] m_va0     = 16'd0;
  logic [15:0] m_va1     = 16'd0;
  logic [15:0] m_hold    = 16'd0;
  logic [15:0] m_vid     = 16'd0;
  logic [7:0]  m_di      = 8'd0;
  logic [7:0]  m_di_prev = 8'd0;

  vram_slot_arbiter #(.RAM_LAT(1)) dut_lat1 (
    .CLOCK(clock), .nRESET(rst_n), .CRTC_CLKEN(clken_1), .MA(ma), .RA(ra),
    .CPU_REQ(cpu_req), .CPU_WE(cpu_we), .CPU_ADDR(cpu_addr), .CPU_DO(cpu_do),
    .CPU_DI(cpu_di_1), .CPU_ACK(ack_1), .CPU_WAIT_n(wait_n_1),
    .RAM_ADDR(ram_addr_1), .RAM_WE(ram_we_1), .RAM_DO(ram_do_1), .RAM_DI(ram_di_1),
    .VID_DATA(vid_data_1), .VID_STB(vid_stb_1)
  );

  vram_slot_arbiter #(.RAM_LAT(2)) dut_lat2 (
    .CLOCK(clock), .nRESET(rst_n), .CRTC_CLKEN(clken_2), .MA(ma), .RA(ra),
    .CPU_REQ(cpu_req), .CPU_WE(cpu_we), .CPU_ADDR(cpu_addr), .CPU_DO(cpu_do),
    .CPU_DI(cpu_di_2), .CPU_ACK(ack_2), .CPU_WAIT_n(wait_n_2),
    .RAM_ADDR(ram_addr_2), .RAM_WE(ram_we_2), .RAM_DO(ram_do_2), .RAM_DI(ram_di_2),
    .VID_DATA(vid_data_2), .VID_STB(vid_stb_2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM models: one registered stage for latency 1, two for latency 2.
  always @(posedge clock) begin
    if (ram_we_1) mem_1[ram_addr_1] <= ram_do_1;
    ram_di_1 <= mem_1[ram_addr_1];
    if (ram_we_2) mem_2[ram_addr_2] <= ram_do_2;
    rd_stage_2 <= mem_2[ram_addr_2];
    ram_di_2   <= rd_stage_2;
  end

  function automatic logic [15:0] va(input logic [13:0] a, input logic [4:0] r, input logic b);
    return {a[13:12], r[2:0], a[9:0], b};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_dut(input int lat, input string tag, input logic clken, input logic stb,
                             input logic [15:0] vid, input logic [15:0] addr, input logic we,
                             input logic [7:0] dout, input logic ack, input logic wait_n,
                             input logic [7:0] di);
    logic [15:0] exp_addr;
    logic        exp_we;
    logic        exp_ack;
    logic [7:0]  exp_di;
    if (m_ph >= 1 && m_ph <= 4)      exp_addr = m_va0;
    else if (m_ph >= 5 && m_ph <= 8) exp_addr = m_va1;
    else                             exp_addr = m_hold;
    exp_we  = t_valid && t_we && (m_ph == 10);
    exp_ack = t_valid && (m_ph == 12);
    if (t_valid && !t_we && m_ph >= 9 && m_ph <= 9 + lat) exp_di = m_di_prev;
    else                                                  exp_di = m_di;
    check_output({tag, ".clken"},    32'(clken),  32'(m_ph == 15));
    check_output({tag, ".vid_stb"},  32'(stb),    32'(m_ph == 8));
    check_output({tag, ".vid_data"}, 32'(vid),    32'(m_vid));
    check_output({tag, ".ram_addr"}, 32'(addr),   32'(exp_addr));
    check_output({tag, ".ram_we"},   32'(we),     32'(exp_we));
    if (exp_we) check_output({tag, ".ram_do"}, 32'(dout), 32'(t_data));
    check_output({tag, ".cpu_ack"},  32'(ack),    32'(exp_ack));
    check_output({tag, ".wait_n"},   32'(wait_n), 32'(!(cpu_req && !exp_ack)));
    check_output({tag, ".cpu_di"},   32'(di),     32'(exp_di));
  endtask

  // Slot-level model: advance on each edge, then compare both instances.
  always @(posedge clock) begin
    if (!rst_n) begin
      m_ph = 0; t_valid = 1'b0; t_we = 1'b0; m_va0 = 16'd0; m_va1 = 16'd0;
      m_hold = 16'd0; m_vid = 16'd0; m_di = 8'd0; m_di_prev = 8'd0;
    end else begin
      case (m_ph)
        0: m_va0 = va(ma, ra, 1'b0);
        4: m_va1 = va(ma, ra, 1'b1);
        7: m_vid = {shadow[m_va1], shadow[m_va0]};
        8: begin
          if (cpu_req) begin
            t_valid = 1'b1; t_we = cpu_we; t_addr = cpu_addr; t_data = cpu_do;
            m_hold  = cpu_addr;
            if (!cpu_we) begin
              m_di_prev = m_di;
              m_di      = shadow[cpu_addr];
            end
          end else begin
            m_hold = m_va1;
          end
        end
        12: begin
          if (t_valid && t_we) shadow[t_addr] = t_data;
          t_valid = 1'b0;
        end
        default: ;
      endcase
      m_ph = (m_ph + 1) % 16;
    end
    #2;
    compare_dut(1, "lat1", clken_1, vid_stb_1, vid_data_1, ram_addr_1, ram_we_1, ram_do_1,
                ack_1, wait_n_1, cpu_di_1);
    compare_dut(2, "lat2", clken_2, vid_stb_2, vid_data_2, ram_addr_2, ram_we_2, ram_do_2,
                ack_2, wait_n_2, cpu_di_2);
  end

  task automatic wait_ph(input int p);
    int n = 0;
    while (m_ph != p && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (m_ph != p) check_output("wait_ph", 32'(m_ph), 32'(p));
  endtask

  task automatic apply_stimulus(input logic req, input logic we, input logic [15:0] addr,
                                input logic [7:0] data);
    cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_do = data;
  endtask

  task automatic cycles_to_clken(output int n, output logic saw_ack);
    n = 0;
    saw_ack = 1'b0;
    while (!clken_1 && n < 40) begin
      @(negedge clock);
      n++;
      if (ack_1 || ack_2) saw_ack = 1'b1;
    end
  endtask

  task automatic cycles_to_ack(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!ack_1 && n < 40);
  endtask

  initial begin
    int n;
    logic saw_ack;
    for (int a = 0; a < 65536; a++) begin
      mem_1[a] = 8'(a); mem_2[a] = 8'(a); shadow[a] = 8'(a);
    end
    mem_1[16'h8000] = 8'hA7; mem_2[16'h8000] = 8'hA7; shadow[16'h8000] = 8'hA7;
    rst_n = 1'b0;
    ma = 14'h3000;
    ra = 5'd2;
    apply_stimulus(1'b0, 1'b0, 16'h0000, 8'h00);
    repeat (3) @(negedge clock);

    check_output("reset.ram_addr", 32'(ram_addr_1), 32'h0);
    check_output("reset.vid_data", 32'(vid_data_2), 32'h0);
    check_output("reset.cpu_di",   32'(cpu_di_1),   32'h0);
    check_output("reset.clken",    32'(clken_2),    32'h0);

    rst_n = 1'b1;
    cycles_to_clken(n, saw_ack);
    check_output("first_clken_delay", 32'(n), 32'd15);

    wait_ph(1);
    check_output("va0.lat1", 32'(ram_addr_1), 32'hD000);
    check_output("va0.lat2", 32'(ram_addr_2), 32'hD000);
    wait_ph(5);
    check_output("va1.lat1", 32'(ram_addr_1), 32'hD001);
    wait_ph(8);
    check_output("vid_stb.lat1",  32'(vid_stb_1),  32'h1);
    check_output("vid_data.lat1", 32'(vid_data_1), 32'h0100);
    check_output("vid_data.lat2", 32'(vid_data_2), 32'h0100);

    wait_ph(15);
    ma = 14'h2C55;
    ra = 5'h1B;
    wait_ph(1);
    check_output("va0_ignored_bits", 32'(ram_addr_2), 32'h98AA);
    wait_ph(8);
    check_output("vid_data_alt.lat2", 32'(vid_data_2), 32'hABAA);

    wait_ph(3);
    apply_stimulus(1'b1, 1'b1, 16'h4123, 8'h5A);
    #1;
    check_output("wr.wait_low", 32'(wait_n_1), 32'h0);
    wait_ph(9);
    check_output("wr.addr", 32'(ram_addr_1), 32'h4123);
    check_output("wr.we_ph9", 32'(ram_we_1), 32'h0);
    wait_ph(10);
    check_output("wr.we_ph10", 32'(ram_we_2), 32'h1);
    check_output("wr.do", 32'(ram_do_2), 32'h5A);
    wait_ph(11);
    check_output("wr.we_ph11", 32'(ram_we_1), 32'h0);
    wait_ph(12);
    check_output("wr.ack", 32'(ack_1), 32'h1);
    check_output("wr.wait_high", 32'(wait_n_1), 32'h1);
    apply_stimulus(1'b0, 1'b0, 16'h0000, 8'h00);

    wait_ph(9);
    apply_stimulus(1'b1, 1'b0, 16'h8000, 8'h00);
    cycles_to_ack(n);
    check_output("rd.latency", 32'(n), 32'd19);
    check_output("rd.di.lat1", 32'(cpu_di_1), 32'hA7);
    check_output("rd.di.lat2", 32'(cpu_di_2), 32'hA7);
    cpu_addr = 16'h4123;
    cycles_to_ack(n);
    check_output("b2b.spacing", 32'(n), 32'd16);
    check_output("b2b.di.lat2", 32'(cpu_di_2), 32'h5A);
    apply_stimulus(1'b0, 1'b0, 16'h0000, 8'h00);

    wait_ph(0);
    apply_stimulus(1'b1, 1'b1, 16'h0040, 8'h33);
    wait_ph(10);
    check_output("rst.we_before", 32'(ram_we_1), 32'h1);
    rst_n = 1'b0;
    #1;
    check_output("rst.we.lat1",   32'(ram_we_1),   32'h0);
    check_output("rst.we.lat2",   32'(ram_we_2),   32'h0);
    check_output("rst.addr",      32'(ram_addr_1), 32'h0);
    check_output("rst.vid_data",  32'(vid_data_1), 32'h0);
    check_output("rst.cpu_di",    32'(cpu_di_2),   32'h0);
    apply_stimulus(1'b0, 1'b0, 16'h0000, 8'h00);
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    cycles_to_clken(n, saw_ack);
    check_output("rst.clken_delay", 32'(n), 32'd15);
    check_output("rst.no_ack", 32'(saw_ack), 32'h0);

    repeat (36) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
